// File: rtl/counter_mod_n_updown_pkg.sv
// ============================================================================
// counter_mod_n_updown_pkg : shared constants and helpers for the mod-N counter
// Rev 1.0
// ============================================================================
`default_nettype none

package counter_mod_n_updown_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_mod_n_updown_prescaler_tick.sv
// ============================================================================
// prescaler_tick : divides enabled cycles by PRESCALE, tick on the last one
// Rev 1.0
// ============================================================================
`default_nettype none

module prescaler_tick
  import counter_mod_n_updown_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : g_passthru
      logic w_unused;
      assign w_unused = &{1'b0, clk, reset, en, clear};
      assign tick     = 1'b1;
    end else begin : g_count
      localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
      localparam logic [PW-1:0] c_last = PW'(PRESCALE - 1);

      logic [PW-1:0] psc_q;
      logic [PW-1:0] psc_d;

      always_comb begin
        psc_d = psc_q;
        if (clear) begin
          psc_d = '0;
        end else if (en) begin
          psc_d = (psc_q == c_last) ? '0 : psc_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          psc_q <= '0;
        end else begin
          psc_q <= psc_d;
        end
      end

      assign tick = (psc_q == c_last);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/counter_mod_n_updown.sv
// ============================================================================
// counter_mod_n_updown : mod-N up/down counter, prescaler, clear, load, flags
// Rev 1.0
// ============================================================================
`default_nettype none

module counter_mod_n_updown
  import counter_mod_n_updown_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int MOD      = 20,
  parameter int PRESCALE = 1,
  parameter int SATURATE = CNT_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             rollover,
  output logic             load_err
);

  generate
    if ((MOD < 2) || (MOD > (1 << WIDTH))) begin : g_bad_params
      $error("counter_mod_n_updown: MOD must satisfy 2 <= MOD <= 2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] c_max = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             rollover_q;
  logic             rollover_d;
  logic             load_err_q;
  logic             load_err_d;
  logic             w_tick;
  logic             w_step;
  logic             w_at_term;
  logic             w_psc_en;

  // A load cycle must not advance the prescaler.
  assign w_psc_en = en & ~load;

  prescaler_tick #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (w_psc_en),
    .clear (clear),
    .tick  (w_tick)
  );

  assign w_step    = en & w_tick;
  assign w_at_term = up ? (count_q == c_max) : (count_q == '0);

  always_comb begin
    count_d    = count_q;
    rollover_d = 1'b0;
    load_err_d = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      if (load_val > c_max) begin
        count_d    = c_max;
        load_err_d = 1'b1;
      end else begin
        count_d = load_val;
      end
    end else if (w_step) begin
      if (w_at_term) begin
        if (SATURATE == CNT_WRAP) begin
          count_d    = up ? '0 : c_max;
          rollover_d = 1'b1;
        end
      end else begin
        count_d = up ? count_q + 1'b1 : count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q    <= '0;
      rollover_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rollover_q <= rollover_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign tc       = w_step & w_at_term;
  assign rollover = rollover_q;
  assign load_err = load_err_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_mod_n_updown.sv
// ============================================================================
// tb_counter_mod_n_updown : wrap, saturate and prescaled instances vs. a model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_counter_mod_n_updown;

  localparam int WIDTH = 5;
  localparam int MOD   = 20;
  localparam int NDUT  = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             up;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;

  logic [WIDTH-1:0] count_w, count_s, count_p;
  logic             tc_w, tc_s, tc_p;
  logic             roll_w, roll_s, roll_p;
  logic             lerr_w, lerr_s, lerr_p;

  always #10 clk = ~clk;

  counter_mod_n_updown #(.WIDTH(WIDTH), .MOD(MOD), .PRESCALE(1), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .count(count_w), .tc(tc_w), .rollover(roll_w), .load_err(lerr_w));

  counter_mod_n_updown #(.WIDTH(WIDTH), .MOD(MOD), .PRESCALE(1), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .count(count_s), .tc(tc_s), .rollover(roll_s), .load_err(lerr_s));

  counter_mod_n_updown #(.WIDTH(WIDTH), .MOD(MOD), .PRESCALE(4), .SATURATE(0)) dut_psc (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .count(count_p), .tc(tc_p), .rollover(roll_p), .load_err(lerr_p));

  int n_vec = 0;
  int n_err = 0;

  // Reference state: plain integers, one entry per instance.
  int m_cnt  [NDUT];
  int m_psc  [NDUT];
  int m_roll [NDUT];
  int m_lerr [NDUT];
  string nm  [NDUT] = '{"wrap", "sat", "psc"};

  function automatic int sat_of(input int i);
    return (i == 1) ? 1 : 0;
  endfunction

  function automatic int psc_of(input int i);
    return (i == 2) ? 4 : 1;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_tc(input int i);
    int term;
    term = up ? (m_cnt[i] == MOD - 1) : (m_cnt[i] == 0);
    return (en && (m_psc[i] == psc_of(i) - 1) && term) ? 1 : 0;
  endfunction

  task automatic model_edge(input int i);
    int nxt;
    int tick;
    if (!reset || clear) begin
      m_cnt[i] = 0; m_psc[i] = 0; m_roll[i] = 0; m_lerr[i] = 0;
    end else if (load) begin
      m_roll[i] = 0;
      if (int'(load_val) < MOD) begin
        m_cnt[i] = int'(load_val); m_lerr[i] = 0;
      end else begin
        m_cnt[i] = MOD - 1; m_lerr[i] = 1;
      end
    end else begin
      m_roll[i] = 0; m_lerr[i] = 0;
      if (en) begin
        tick     = (m_psc[i] == psc_of(i) - 1);
        m_psc[i] = (m_psc[i] + 1) % psc_of(i);
        if (tick) begin
          nxt = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
          if (nxt < 0 || nxt >= MOD) begin
            if (sat_of(i) == 0) begin
              m_cnt[i]  = (nxt + MOD) % MOD;
              m_roll[i] = 1;
            end
          end else begin
            m_cnt[i] = nxt;
          end
        end
      end
    end
  endtask

  task automatic check_regs(input int i, input int c, input int r, input int e);
    check($sformatf("%s.count", nm[i]), c, m_cnt[i]);
    check($sformatf("%s.rollover", nm[i]), r, m_roll[i]);
    check($sformatf("%s.load_err", nm[i]), e, m_lerr[i]);
  endtask

  // Called 1 time unit after a rising edge; leaves time 1 unit after the next one.
  task automatic apply(input logic r_n, input logic e, input logic u, input logic c,
                       input logic l, input int lv);
    reset    = r_n;
    en       = e;
    up       = u;
    clear    = c;
    load     = l;
    load_val = WIDTH'(lv);
    #5;
    check("wrap.tc", int'(tc_w), exp_tc(0));
    check("sat.tc",  int'(tc_s), exp_tc(1));
    check("psc.tc",  int'(tc_p), exp_tc(2));
    @(posedge clk);
    for (int i = 0; i < NDUT; i++) model_edge(i);
    #1;
    check_regs(0, int'(count_w), int'(roll_w), int'(lerr_w));
    check_regs(1, int'(count_s), int'(roll_s), int'(lerr_s));
    check_regs(2, int'(count_p), int'(roll_p), int'(lerr_p));
  endtask

  initial begin
    logic r_up;
    reset = 1'b0; en = 1'b1; up = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;
    for (int i = 0; i < NDUT; i++) begin
      m_cnt[i] = 0; m_psc[i] = 0; m_roll[i] = 0; m_lerr[i] = 0;
    end
    @(posedge clk);
    #1;

    // Held in reset with enable high, then free-running up through a wrap.
    for (int k = 0; k < 5; k++)  apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    for (int k = 0; k < 25; k++) apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);

    // Down from zero wraps to MOD-1; enable low holds.
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    for (int k = 0; k < 4; k++)  apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    for (int k = 0; k < 3; k++)  apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // In-range, out-of-range and clear-beats-load.
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 7);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 25);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 31);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9);

    // Up from 17 into the top end, then all the way down past zero.
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 17);
    for (int k = 0; k < 6; k++)  apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    for (int k = 0; k < 23; k++) apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Prescaler: pause mid-prescale, then reset mid-run.
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    for (int k = 0; k < 6; k++)  apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    for (int k = 0; k < 2; k++)  apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    for (int k = 0; k < 8; k++)  apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    for (int k = 0; k < 9; k++)  apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);

    // Random traffic; direction is sticky so runs reach both ends.
    r_up = 1'b1;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 15) == 0) r_up = ~r_up;
      apply(($urandom_range(0, 59) != 0),
            ($urandom_range(0, 3) != 0),
            r_up,
            ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 11) == 0),
            int'($urandom_range(0, 31)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
